dmem_arbiter: RTL and testbench

- Arbitrates the single-port data memory between the pipeline Memory stage (CPU) and the display pixel-fetch engine.
- Grants one requester per cycle and stalls the CPU when it loses.
- Returns read data one cycle after grant, tagged to its owner.
- Sits between the Memory stage and the Data_Memory instance; the memory itself is unchanged.

---
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port memory between the CPU MEM stage and the display fetch engine.
// Optional DMEM_ARB_PERF_EN adds saturating stall/grant performance counters.
module dmem_arbiter #(
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 19,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic              cpu_byte,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic [7:0]        disp_pixel,
   output logic              mem_en,
   output logic              mem_we,
   output logic              mem_byte,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [15:0]       perf_stall_cnt,
   output logic [15:0]       perf_disp_cnt
`endif
);

   typedef struct packed {
      logic              we;
      logic              byte_sel;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic cpu_rd;
      logic disp_rd;
   } rd_tag_t;

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   logic [3:0]        wait_cnt, wait_eff, wait_nxt;
   logic              cpu_grant, disp_grant;
   mem_req_t          mem_r;
   rd_tag_t           tag_q, tag_d;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [7:0]        disp_pixel_q;

   // Grant logic stays live during reset, so the counter is seen as zero there.
   assign wait_eff = reset ? wait_cnt : 4'd0;

   always_comb begin
      disp_grant = disp_req & (~cpu_req | (wait_eff >= MAX_W));
      cpu_grant  = cpu_req & ~disp_grant;
   end

   assign cpu_stall = cpu_req & ~cpu_grant;
   assign disp_gnt  = disp_req & disp_grant;

   always_comb begin
      mem_r = '0;
      if (cpu_grant) begin
         mem_r.we       = cpu_we;
         mem_r.byte_sel = cpu_byte;
         mem_r.addr     = cpu_addr;
         mem_r.wdata    = cpu_wdata;
      end else if (disp_grant) begin
         mem_r.addr     = disp_addr;
      end
   end

   assign mem_en    = cpu_grant | disp_grant;
   assign mem_we    = mem_r.we;
   assign mem_byte  = mem_r.byte_sel;
   assign mem_addr  = mem_r.addr;
   assign mem_wdata = mem_r.wdata;

   always_comb begin
      wait_nxt = wait_cnt;
      if (disp_gnt)
         wait_nxt = 4'd0;
      else if (disp_req && (wait_cnt < MAX_W))
         wait_nxt = wait_cnt + 4'd1;
   end

   always_comb begin
      tag_d         = '0;
      tag_d.cpu_rd  = cpu_grant & ~cpu_we;
      tag_d.disp_rd = disp_grant;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt     <= 4'd0;
         tag_q        <= '0;
         cpu_rdata_q  <= '0;
         disp_pixel_q <= '0;
      end else begin
         wait_cnt <= wait_nxt;
         tag_q    <= tag_d;
         if (tag_q.cpu_rd)  cpu_rdata_q  <= mem_rdata;
         if (tag_q.disp_rd) disp_pixel_q <= mem_rdata[7:0];
      end
   end

   // Return data is passed straight through on the valid cycle, then held.
   assign cpu_rvalid  = tag_q.cpu_rd;
   assign disp_rvalid = tag_q.disp_rd;
   assign cpu_rdata   = tag_q.cpu_rd  ? mem_rdata      : cpu_rdata_q;
   assign disp_pixel  = tag_q.disp_rd ? mem_rdata[7:0] : disp_pixel_q;

`ifdef DMEM_ARB_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_cnt <= 16'd0;
         perf_disp_cnt  <= 16'd0;
      end else begin
         if (cpu_stall && (perf_stall_cnt != 16'hFFFF)) perf_stall_cnt <= perf_stall_cnt + 16'd1;
         if (disp_gnt  && (perf_disp_cnt  != 16'hFFFF)) perf_disp_cnt  <= perf_disp_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps plus random traffic against a rule-level reference model.
module tb_dmem_arbiter;
   localparam int ADDR_W   = 19;
   localparam int DATA_W   = 19;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              cpu_req, cpu_we, cpu_byte;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall, cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_gnt, disp_rvalid;
   logic [7:0]        disp_pixel;
   logic              mem_en, mem_we, mem_byte;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
   logic [15:0]       perf_stall_cnt, perf_disp_cnt;
`endif

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_rvalid(disp_rvalid), .disp_pixel(disp_pixel),
      .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_disp_cnt(perf_disp_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: how long display has been starved, and what is in flight
   int                starve = 0;
   bit                pend_c = 0, pend_d = 0;
   logic [DATA_W-1:0] last_c = '0;
   logic [7:0]        last_p = '0;
   int                n_stall = 0, n_dg = 0;
   bit                last_stall = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_clear();
      starve = 0; pend_c = 0; pend_d = 0; last_c = '0; last_p = '0;
   endtask

   // One clock cycle: drive, check just before the edge, advance the model at the edge.
   task automatic step(input bit c_req, input bit c_we, input bit c_byte,
                       input logic [ADDR_W-1:0] c_addr, input logic [DATA_W-1:0] c_wd,
                       input bit d_req, input logic [ADDR_W-1:0] d_addr,
                       input logic [DATA_W-1:0] rd, output bit o_dgnt);
      bit dwin, cwin;
      cpu_req = c_req; cpu_we = c_we; cpu_byte = c_byte; cpu_addr = c_addr; cpu_wdata = c_wd;
      disp_req = d_req; disp_addr = d_addr; mem_rdata = rd;
      #2;
      dwin = d_req && (!c_req || starve >= MAX_WAIT);
      cwin = c_req && !dwin;
      chk("cpu_stall", 32'(cpu_stall), 32'(c_req && !cwin));
      chk("disp_gnt", 32'(disp_gnt), 32'(dwin));
      chk("mem_en", 32'(mem_en), 32'(cwin || dwin));
      chk("mem_addr", 32'(mem_addr), cwin ? 32'(c_addr) : (dwin ? 32'(d_addr) : 32'd0));
      chk("mem_we", 32'(mem_we), 32'(cwin && c_we));
      chk("mem_byte", 32'(mem_byte), 32'(cwin && c_byte));
      chk("mem_wdata", 32'(mem_wdata), cwin ? 32'(c_wd) : 32'd0);
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(pend_c));
      chk("disp_rvalid", 32'(disp_rvalid), 32'(pend_d));
      chk("cpu_rdata", 32'(cpu_rdata), pend_c ? 32'(rd) : 32'(last_c));
      chk("disp_pixel", 32'(disp_pixel), pend_d ? 32'(rd[7:0]) : 32'(last_p));
      o_dgnt = disp_gnt;
      last_stall = c_req && !cwin;
      @(posedge clk);
      if (reset) begin
         if (pend_c) last_c = rd;
         if (pend_d) last_p = rd[7:0];
         pend_c = cwin && !c_we;
         pend_d = dwin;
         if (dwin) starve = 0;
         else if (d_req) starve = (starve + 1 > MAX_WAIT) ? MAX_WAIT : starve + 1;
         if (c_req && !cwin) n_stall++;
         if (dwin) n_dg++;
      end else begin
         model_clear();
      end
      #1;
   endtask

   initial begin
      bit g;
      bit c_req, c_we, c_byte, d_req;
      logic [ADDR_W-1:0] c_addr, d_addr;
      logic [DATA_W-1:0] c_wd;

      reset = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_byte = 0; cpu_addr = '0; cpu_wdata = '0;
      disp_req = 0; disp_addr = '0; mem_rdata = '0;
      #1;
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      chk("rst_disp_pixel", 32'(disp_pixel), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      @(posedge clk); #1;
      step(1, 0, 0, 19'h00100, '0, 1, 19'h04000, '0, g);   // during reset: CPU wins, no starvation
      chk("rst_conflict_gnt", 32'(g), 32'd0);
      reset = 1'b1;
      n_stall = 0; n_dg = 0;

      // continuous conflict: display must break through on the fifth cycle of each five
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0, 19'h00100, 19'(i), 1, 19'h04000, 19'(i), g);
         chk($sformatf("conflict_gnt_%0d", i), 32'(g), 32'(i == 4 || i == 9));
      end
`ifdef DMEM_ARB_PERF_EN
      chk("perf_stall", 32'(perf_stall_cnt), 32'd2);
      chk("perf_disp", 32'(perf_disp_cnt), 32'd2);
`endif

      // CPU read only
      step(1, 0, 0, 19'h00010, '0, 0, '0, 19'h00000, g);
      step(0, 0, 0, '0, '0, 0, '0, 19'h12345, g);
      chk("cpu_read_data", 32'(last_c), 32'h12345);

      // display only
      step(0, 0, 0, '0, '0, 1, 19'h04000, '0, g);
      chk("disp_only_gnt", 32'(g), 32'd1);
      step(0, 0, 0, '0, '0, 0, '0, 19'h000A7, g);
      chk("disp_pixel_val", 32'(last_p), 32'hA7);

      // CPU byte write, then no read return
      step(1, 1, 1, 19'h00020, 19'h000FF, 0, '0, '0, g);
      step(0, 0, 0, '0, '0, 0, '0, 19'h3FFFF, g);

      // reset landing right after a CPU read is granted
      step(1, 0, 0, 19'h00030, '0, 0, '0, '0, g);
      reset = 1'b0;
      model_clear();
      cpu_req = 0; mem_rdata = 19'h5A5A5;
      #2;
      chk("rst_mid_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_mid_rdata", 32'(cpu_rdata), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      step(0, 0, 0, '0, '0, 0, '0, 19'h11111, g);
      step(0, 0, 0, '0, '0, 1, 19'h00055, '0, g);  // starvation counter restarted at zero

      // random traffic; CPU holds while stalled, display may drop
      c_req = 0; c_we = 0; c_byte = 0; c_addr = '0; c_wd = '0; d_req = 0; d_addr = '0;
      for (int i = 0; i < 400; i++) begin
         if (!last_stall) begin
            c_req  = ($urandom_range(0, 3) != 0);
            c_we   = $urandom_range(0, 1);
            c_byte = $urandom_range(0, 1);
            c_addr = 19'($urandom);
            c_wd   = 19'($urandom);
         end
         if (!(d_req && !g && $urandom_range(0, 3) != 0)) begin
            d_req  = ($urandom_range(0, 2) != 0);
            d_addr = 19'($urandom);
         end
         step(c_req, c_we, c_byte, c_addr, c_wd, d_req, d_addr, 19'($urandom), g);
      end
`ifdef DMEM_ARB_PERF_EN
      chk("perf_stall_total", 32'(perf_stall_cnt), 32'(n_stall));
      chk("perf_disp_total", 32'(perf_disp_cnt), 32'(n_dg));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
